dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the data-memory interface driven by the memory pipeline stage.
- Accepts one load/store request at a time over a valid/ready handshake and holds it for a programmable access latency.
- Commits stores with byte-lane masking; returns loads sign- or zero-extended per RV32I funct3.
- Replaces the single-cycle data memory so the core can be tested against slow memory with backpressure.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  access size/sign, instruction bits [14:12].
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  illegal funct3, or misaligned access when MISALIGN_TRAP_EN is defined.

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- The memory array is not reset; its contents survive rst.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, latch we/funct3/addr/wdata.
  - Load counter with LATENCY-1.
  - Go to WAIT, or directly to the access if LATENCY=1.
- WAIT:
  - req_ready=0; decrement the counter each cycle.
  - At the edge where counter==0, perform the access and go to RESP.
  - Result: rsp_valid rises exactly LATENCY edges after the accepting edge.
- Access:
  - Word index = addr[ADDR_W+1:2]; upper address bits are ignored, so accesses wrap modulo memory size.
  - Stores:
    - SB (000) writes lane addr[1:0].
    - SH (001) writes lanes 2*addr[1]..+1.
    - SW (010) writes all lanes.
  - Loads:
    - LB (000) and LH (001) sign-extend.
    - LW (010) returns the full word.
    - LBU (100) and LHU (101) zero-extend.
    - Lane is selected by addr[1:0].
  - Any other funct3: no write, rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_ready, go to IDLE next cycle with rsp_valid=0.
  - No new request is accepted in the same cycle; at most one request is outstanding.
- Back-to-back throughput: one request per LATENCY+2 cycles when rsp_ready is held high.
- Stores also produce a response (rdata=0) to acknowledge commit.
- A reset asserted during WAIT drops the pending request; a store not yet committed is never written.
- A reset asserted during RESP discards the response.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, set rsp_err=1.
  - The store is suppressed and rdata=0.
- Undefined:
  - Misaligned low address bits are masked (half: addr[0] forced 0; word: addr[1:0] forced 0).
  - The access proceeds normally and rsp_err reflects only illegal funct3.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding IDLE/WAIT/RESP.
  - The LATENCY upper bound.
- One combinational sub-module, mem_lane_align, produces 4-bit byte strobes and shifted write data from funct3/addr/wdata, plus load extraction/extension from the read word.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF followed by LW 0x10, LATENCY=2 -> rsp_valid 2 edges after each accept; LW rdata=0xDEADBEEF, rsp_err=0.
- SB 0x80 to addr 0x13, then LB 0x13 and LBU 0x13 -> rdata 0xFFFFFF80 and 0x00000080; bytes 0x10–0x12 unchanged.
- SH 0x8001 to 0x22, then LH 0x22 and LHU 0x22 -> 0xFFFF8001 and 0x00008001; lower half of word 0x20 unchanged.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rdata stable, req_ready=0, and a new req_valid is not accepted until 1 cycle after the response handshake.
- Accept SW 0x40 data 0x12345678, pull rst low during WAIT, release, then LW 0x40 -> old contents returned, the write never happened, and outputs are 0 during reset.
- funct3=011 load -> rsp_err=1, rdata=0. With MISALIGN_TRAP_EN, LW 0x41 -> rsp_err=1. Without it, LW 0x41 -> word at 0x40, rsp_err=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory responder: funct3 access codes, FSM states, latency bound.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and load extraction/extension.
// MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of masking the low bits.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        err
);

  logic        legal;
  logic        misal;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [3:0]  be_raw;
  logic [31:0] ld_val;

  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    off   = addr_lo;
    case (funct3)
      F3_B:  legal = 1'b1;
      F3_BU: legal = !we;
      F3_H: begin
        legal = 1'b1;
        misal = addr_lo[0];
        off   = {addr_lo[1], 1'b0};
      end
      F3_HU: begin
        legal = !we;
        misal = addr_lo[0];
        off   = {addr_lo[1], 1'b0};
      end
      F3_W: begin
        legal = 1'b1;
        misal = |addr_lo;
        off   = 2'b00;
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign err = !legal || misal;
`else
  logic unused_misal;
  assign unused_misal = misal;
  assign err = !legal;
`endif

  assign shifted = rword >> {off, 3'b000};

  always_comb begin
    be_raw   = 4'b0000;
    wdata_sh = 32'h0;
    ld_val   = 32'h0;
    case (funct3)
      F3_B: begin
        be_raw   = 4'(4'b0001 << off);
        wdata_sh = {4{wdata[7:0]}};
        ld_val   = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: ld_val = {24'h0, shifted[7:0]};
      F3_H: begin
        be_raw   = 4'(4'b0011 << off);
        wdata_sh = {2{wdata[15:0]}};
        ld_val   = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_HU: ld_val = {16'h0, shifted[15:0]};
      F3_W: begin
        be_raw   = 4'b1111;
        wdata_sh = wdata;
        ld_val   = rword;
      end
      default: ;
    endcase
  end

  // Errors suppress both the store and the load data; stores never return data.
  assign be    = (we && !err) ? be_raw : 4'b0000;
  assign rdata = (!we && !err) ? ld_val : 32'h0;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with LATENCY-cycle access delay and held responses.
// Optional MISALIGN_TRAP_EN makes misaligned half/word accesses report rsp_err.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_lat_check
    $error("dmem_responder: LATENCY out of range");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lo_q, lo_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rword;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_err;
  logic        access;

  // Upper address bits are deliberately dropped so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign rword  = mem[idx_q];
  assign access = (state_q == WAIT) && (cnt_q == '0);

  mem_lane_align u_align (
    .we       (we_q),
    .funct3   (f3_q),
    .addr_lo  (lo_q),
    .wdata    (wdata_q),
    .rword    (rword),
    .be       (al_be),
    .wdata_sh (al_wdata),
    .rdata    (al_rdata),
    .err      (al_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          f3_d        = req_funct3;
          idx_d       = req_addr[ADDR_W+1:2];
          lo_d        = req_addr[1:0];
          wdata_d     = req_wdata;
          cnt_d       = CNT_W'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = al_rdata;
          rsp_err_d   = al_err;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      idx_q       <= '0;
      lo_q        <= 2'b00;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is not reset; a reset forces state to IDLE, which blocks any pending commit.
  always_ff @(posedge clk) begin
    if (access) begin
      for (int b = 0; b < 4; b++) begin
        if (al_be[b]) mem[idx_q][8*b +: 8] <= al_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model with per-cycle output checks.
module tb_dmem_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;
  localparam int NBYTES  = 4 * (1 << ADDR_W);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  mem_m [0:NBYTES-1];
  logic        chk_en  = 1'b0;
  logic        in_rst  = 1'b0;
  logic        out_act = 1'b0;
  int          acc_cyc = 0;
  int          rise_cyc = 0;
  logic [31:0] exp_rdata, got_rdata, p_wd;
  logic        exp_err, got_err, p_wr;
  int          p_base, p_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, size from funct3[1:0], sign from funct3[2].
  function automatic void model_eval(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                     output logic [31:0] rd, output logic er,
                                     output logic wr, output int base, output int n);
    int sz, off;
    logic legal;
    rd = 32'h0; er = 1'b0; wr = 1'b0; base = 0; n = 0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin er = 1'b1; return; end
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
`ifdef MISALIGN_TRAP_EN
    if (off % sz != 0) begin er = 1'b1; return; end
`else
    off = off - (off % sz);
`endif
    base = int'((a >> 2) % (NBYTES / 4)) * 4 + off;
    if (we) begin
      wr = 1'b1; n = sz;
    end else begin
      for (int i = 0; i < sz; i++) rd = rd | (32'(mem_m[base + i]) << (8 * i));
      if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFF_FFFF << (8 * sz));
    end
  endfunction

  task automatic drive_junk();
    req_valid  = 1'b1;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    acc_cyc = cyc;
    model_eval(we, f3, a, exp_rdata, exp_err, p_wr, p_base, p_n);
    p_wd    = wd;
    out_act = 1'b1;
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int hold);
    int t;
    present(we, f3, a, wd);
    t = 0;
    while (!rsp_valid && t < 40) begin
      drive_junk();
      rsp_ready = 1'($urandom);
      @(posedge clk); #1;
      t++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      out_act = 1'b0; req_valid = 1'b0;
      return;
    end
    rise_cyc  = cyc;
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    if (p_wr) for (int i = 0; i < p_n; i++) mem_m[p_base + i] = p_wd[8*i +: 8];
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      drive_junk();
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    out_act   = 1'b0;
    rsp_ready = 1'b0;
  endtask

  // Per-cycle compare against the model's expected timing and data.
  always @(negedge clk) begin
    if (chk_en) begin
      if (in_rst) begin
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
      end else if (out_act) begin
        check("busy_req_ready", 32'(req_ready), 32'd0);
        check("rsp_valid_timing", 32'(rsp_valid), 32'(cyc >= acc_cyc + LATENCY));
        if (cyc >= acc_cyc + LATENCY) begin
          check("rsp_rdata", rsp_rdata, exp_rdata);
          check("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
      end else begin
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev;
    logic [31:0] r;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    in_rst = 1'b1; chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b1; in_rst = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < 64; w++) xact(1'b1, 3'b010, 32'(w * 4), $urandom, 0);

    xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
    check("sw_latency", 32'(rise_cyc - acc_cyc), 32'd2);
    check("sw_rdata_zero", got_rdata, 32'h0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0);
    check("lw_latency", 32'(rise_cyc - acc_cyc), 32'd2);
    check("lw_rdata", got_rdata, 32'hDEAD_BEEF);
    check("lw_err", 32'(got_err), 32'd0);

    xact(1'b1, 3'b000, 32'h13, 32'h0000_0080, 0);
    xact(1'b0, 3'b000, 32'h13, 32'h0, 0);
    check("lb_sign", got_rdata, 32'hFFFF_FF80);
    xact(1'b0, 3'b100, 32'h13, 32'h0, 0);
    check("lbu_zero", got_rdata, 32'h0000_0080);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0);
    check("sb_lanes_kept", got_rdata, 32'h80AD_BEEF);

    xact(1'b1, 3'b010, 32'h20, 32'h1122_3344, 0);
    xact(1'b1, 3'b001, 32'h22, 32'h0000_8001, 0);
    xact(1'b0, 3'b001, 32'h22, 32'h0, 0);
    check("lh_sign", got_rdata, 32'hFFFF_8001);
    xact(1'b0, 3'b101, 32'h22, 32'h0, 0);
    check("lhu_zero", got_rdata, 32'h0000_8001);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 0);
    check("sh_lanes_kept", got_rdata, 32'h8001_3344);

    xact(1'b0, 3'b010, 32'h10, 32'h0, 5);
    prev = rise_cyc;
    xact(1'b0, 3'b010, 32'h20, 32'h0, 0);
    check("accept_after_hold", 32'(acc_cyc - prev), 32'd7);
    prev = acc_cyc;
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0);
    check("b2b_period", 32'(acc_cyc - prev), 32'(LATENCY + 2));

    xact(1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 0);
    present(1'b1, 3'b010, 32'h40, 32'h1234_5678);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_rst = 1'b1; out_act = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; in_rst = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 3'b010, 32'h40, 32'h0, 0);
    check("store_dropped_by_reset", got_rdata, 32'h0BAD_F00D);

    xact(1'b0, 3'b011, 32'h40, 32'h0, 0);
    check("bad_f3_err", 32'(got_err), 32'd1);
    check("bad_f3_rdata", got_rdata, 32'h0);

    xact(1'b0, 3'b010, 32'h41, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    check("lw_misal_err", 32'(got_err), 32'd1);
    check("lw_misal_rdata", got_rdata, 32'h0);
`else
    check("lw_misal_err", 32'(got_err), 32'd0);
    check("lw_misal_rdata", got_rdata, 32'h0BAD_F00D);
`endif

    xact(1'b0, 3'b010, 32'hABCD_E010, 32'h0, 0);
    check("addr_wrap", got_rdata, 32'h80AD_BEEF);

    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      xact(1'($urandom), 3'($urandom), {r[31:12], 4'h0, r[7:0]}, $urandom,
           int'($urandom_range(0, 3)));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
